// File: rtl/seq_pkg.sv
// Shared constants and state type for the burst-link word 1-0-0-0-1-1,
// used by both the generator and the receive-side detector.
package seq_pkg;

    localparam int SEQ_LEN = 6;
    localparam logic [SEQ_LEN-1:0] SEQ_PATTERN = 6'b100011;

    // State index equals the length of the longest matched prefix.
    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4,
        S5 = 3'd5
    } seq_state_t;

endpackage

// File: rtl/sequence_det_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;

endmodule

// File: rtl/sequence_det.sv
// Serial detector for the 6-bit burst word 1-0-0-0-1-1 with overlap support.
// Define SEQ_DET_COUNTER_EN to add the saturating match_count port and counter.
module sequence_det
    import seq_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             din,
    input  logic             din_valid,
    input  logic             count_clr,
    output logic             match,
    output logic [2:0]       state_dbg
`ifdef SEQ_DET_COUNTER_EN
    ,
    output logic [CNT_W-1:0] match_count
`endif
);

    seq_state_t state_q;
    seq_state_t state_d;
    logic       match_q;
    logic       match_d;

    // A mismatching bit falls back to the longest prefix it still completes.
    function automatic seq_state_t next_state(input seq_state_t s, input logic b);
        case (s)
            S0:      return b ? S1 : S0;
            S1:      return b ? S1 : S2;
            S2:      return b ? S1 : S3;
            S3:      return b ? S1 : S4;
            S4:      return b ? S5 : S0;
            S5:      return b ? S1 : S2;
            default: return S0;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        match_d = 1'b0;
        if (din_valid) begin
            state_d = next_state(state_q, din);
            match_d = (state_q == S5) && (din == SEQ_PATTERN[0]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S0;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            match_q <= match_d;
        end
    end

    assign match     = match_q;
    assign state_dbg = state_q;

`ifdef SEQ_DET_COUNTER_EN
    // Counter steps on the same edge that raises match.
    sat_counter #(
        .W(CNT_W)
    ) u_match_cnt (
        .clk  (clk),
        .reset(reset),
        .inc  (match_d),
        .clr  (count_clr),
        .count(match_count)
    );
`else
    logic unused_cnt;
    assign unused_cnt = count_clr & (CNT_W > 0);
`endif

endmodule

// File: tb/tb_sequence_det.sv
// Scoreboard bench for sequence_det: driver queues hand-computed expectations,
// a monitor pops one per cycle just after each rising edge and compares.
module tb_sequence_det;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       din = 1'b0;
    logic       din_valid = 1'b0;
    logic       count_clr = 1'b0;
    logic       match;
    logic [2:0] state_dbg;
`ifdef SEQ_DET_COUNTER_EN
    logic [1:0] match_count;
`endif

    always #5 clk = ~clk;

    sequence_det #(
        .CNT_W(2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .din      (din),
        .din_valid(din_valid),
        .count_clr(count_clr)
        ,
        .match    (match),
        .state_dbg(state_dbg)
`ifdef SEQ_DET_COUNTER_EN
        ,
        .match_count(match_count)
`endif
    );

    typedef struct {
        int st;
        bit m;
        int cnt;
        int idx;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   step_no = 0;

    task automatic step(input bit r, input bit v, input bit d, input bit c,
                        input int es, input bit em, input int ec);
        exp_t e;
        @(negedge clk);
        reset = r;
        din_valid = v;
        din = d;
        count_clr = c;
        e.st = es;
        e.m = em;
        e.cnt = ec;
        e.idx = step_no;
        step_no++;
        exp_q.push_back(e);
    endtask

    task automatic bit_in(input bit d, input int es, input bit em, input int ec);
        step(1'b0, 1'b1, d, 1'b0, es, em, ec);
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (state_dbg !== 3'(e.st)) begin
                failures++;
                $display("FAIL state_dbg step %0d: got %0d expected %0d", e.idx, state_dbg, e.st);
            end
            checks++;
            if (match !== e.m) begin
                failures++;
                $display("FAIL match step %0d: got %0b expected %0b", e.idx, match, e.m);
            end
`ifdef SEQ_DET_COUNTER_EN
            checks++;
            if (match_count !== 2'(e.cnt)) begin
                failures++;
                $display("FAIL match_count step %0d: got %0d expected %0d", e.idx, match_count, e.cnt);
            end
`endif
        end
    end

    initial begin
        int wait_cyc;
        // Reset state
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 1, 0, 0, 0, 0);

        // Single word, then idle hold
        bit_in(1, 1, 0, 0); bit_in(0, 2, 0, 0); bit_in(0, 3, 0, 0);
        bit_in(0, 4, 0, 0); bit_in(1, 5, 0, 0); bit_in(1, 1, 1, 1);
        step(0, 0, 1, 0, 1, 0, 1);

        // Overlapping back-to-back words
        step(1, 0, 0, 0, 0, 0, 0);
        bit_in(1, 1, 0, 0); bit_in(0, 2, 0, 0); bit_in(0, 3, 0, 0);
        bit_in(0, 4, 0, 0); bit_in(1, 5, 0, 0); bit_in(1, 1, 1, 1);
        bit_in(0, 2, 0, 1); bit_in(0, 3, 0, 1); bit_in(0, 4, 0, 1);
        bit_in(1, 5, 0, 1); bit_in(1, 1, 1, 2);

        // Near miss 1,0,0,0,0,1,1
        step(1, 0, 0, 0, 0, 0, 0);
        bit_in(1, 1, 0, 0); bit_in(0, 2, 0, 0); bit_in(0, 3, 0, 0);
        bit_in(0, 4, 0, 0); bit_in(0, 0, 0, 0); bit_in(1, 1, 0, 0);
        bit_in(1, 1, 0, 0);

        // Gap of three invalid cycles mid-word
        step(1, 0, 0, 0, 0, 0, 0);
        bit_in(1, 1, 0, 0); bit_in(0, 2, 0, 0); bit_in(0, 3, 0, 0);
        step(0, 0, 1, 0, 3, 0, 0); step(0, 0, 0, 0, 3, 0, 0); step(0, 0, 1, 0, 3, 0, 0);
        bit_in(0, 4, 0, 0); bit_in(1, 5, 0, 0); bit_in(1, 1, 1, 1);

        // Reset mid-word discards prefix and clears count
        bit_in(0, 2, 0, 1); bit_in(0, 3, 0, 1); bit_in(0, 4, 0, 1); bit_in(1, 5, 0, 1);
        step(1, 1, 1, 0, 0, 0, 0);
        bit_in(1, 1, 0, 0);

        // Saturation with 2-bit counter: five matches
        step(1, 0, 0, 0, 0, 0, 0);
        bit_in(1, 1, 0, 0);
        for (int k = 1; k <= 5; k++) begin
            int c_prev;
            int c_new;
            c_prev = (k - 1 > 3) ? 3 : k - 1;
            c_new = (k > 3) ? 3 : k;
            bit_in(0, 2, 0, c_prev); bit_in(0, 3, 0, c_prev); bit_in(0, 4, 0, c_prev);
            bit_in(1, 5, 0, c_prev); bit_in(1, 1, 1, c_new);
        end

        // Clear coincident with a match wins
        bit_in(0, 2, 0, 3); bit_in(0, 3, 0, 3); bit_in(0, 4, 0, 3); bit_in(1, 5, 0, 3);
        step(0, 1, 1, 1, 1, 1, 0);
        // Clear during idle after a fresh match
        bit_in(0, 2, 0, 0); bit_in(0, 3, 0, 0); bit_in(0, 4, 0, 0); bit_in(1, 5, 0, 0);
        bit_in(1, 1, 1, 1);
        step(0, 0, 0, 1, 1, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);

        wait_cyc = 0;
        while (exp_q.size() > 0 && wait_cyc < 20) begin
            @(negedge clk);
            wait_cyc++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sequence_det.md
# sequence_det

Serial pattern detector for the receive end of the single-bit burst link. It consumes one bit per cycle when qualified and recognises the 6-bit burst word 1-0-0-0-1-1, first bit first, that the link's generator emits on each trigger. It raises a one-cycle registered match pulse per complete word, with overlapping words allowed. An optional saturating match counter sits alongside the detector for link-health monitoring.

## Interface
- CNT_W, 8, width of match counter (only meaningful with counter compiled in; legal range 2..16)
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  reset, synchronous, active-high
- din  input  1  serial data bit
- din_valid  input  1  din qualifier; bit consumed only on edges where high
- count_clr  input  1  synchronous clear of match counter
- match  output  1  one-cycle pulse: last six consumed bits were 100011
- state_dbg  output  3  current FSM state encoding (0..5), debug only
- match_count  output  CNT_W  saturating count of matches (present only with SEQ_DET_COUNTER_EN)

## Operation
- FSM states S0..S5 = length of longest pattern prefix matched so far (S0 = none).
- Transitions on a consumed bit (din_valid=1), din=0 / din=1:
  - S0: S0 / S1
  - S1: S2 / S1
  - S2: S3 / S1
  - S3: S4 / S1
  - S4: S0 / S5
  - S5: S2 / S1, and din=1 in S5 is a match
- After a match, the FSM goes to S1: the trailing 1 starts a new word, so overlap is supported.
- din_valid=0: state holds, match=0, din ignored; gaps of any length are allowed mid-word.
- Near-miss 1-0-0-0-0 returns to S0. No partial credit is kept.
- state_dbg = binary state index, S0=3'd0 .. S5=3'd5; codes 6 and 7 are unreachable.
- Counter (when compiled in):
  - Increments by 1 on each match.
  - Saturates at 2^CNT_W-1 and never wraps.
  - count_clr has priority over an increment in the same cycle; the result is 0.

## Timing
- Reset values: state S0, match=0, state_dbg=0, match_count=0.
- Reset is synchronous and overrides din_valid/count_clr; reset mid-word discards the partial prefix.
- match latency: asserted in the cycle after the rising edge that consumes the sixth bit (registered, no combinational path from din).
- Back-to-back overlapping words produce match pulses at least 5 consumed bits apart; match is never high two consecutive cycles.
- match_count reflects a match on the same edge that raises match, so it is visible together with the pulse.
- First bit following reset deassertion is consumed on the next edge where din_valid=1.

## Configuration
- SEQ_DET_COUNTER_EN defined: match_count port and saturating counter present; count_clr functional.
- Undefined: match_count port and counter logic absent; count_clr present but ignored. Detector behaviour identical.

## Structure
- Shared package seq_pkg:
  - state typedef seq_state_t (S0..S5)
  - SEQ_PATTERN = 6'b100011 (MSB = first bit)
  - SEQ_LEN = 6
  - The generator side uses the same constants.
- One sub-module: sat_counter (parameter W; inc, clr, synchronous reset; saturating), instantiated only under SEQ_DET_COUNTER_EN.

## Test plan
- Reset, then din_valid=1 with bits 1,0,0,0,1,1 -> match high exactly one cycle after the 6th edge; state_dbg returns to 1; match_count=1.
- Bits 1,0,0,0,1,1,0,0,0,1,1 continuous -> two match pulses, 5 cycles apart; match_count=2.
- Bits 1,0,0,0,0,1,1 -> no match; state_dbg sequence 1,2,3,4,0,1,1.
- Pattern with din_valid=0 for 3 cycles after the 3rd bit -> state_dbg holds at 3 during the gap; single match after the 6th valid bit.
- Reset asserted after 1,0,0,0,1, then bit 1 -> no match; state_dbg=1 after that bit; match_count cleared to 0.
- CNT_W=2, five matches -> match_count 1,2,3,3,3. count_clr on the same cycle as a match -> match_count=0 while match pulses.
